sng_stream: RTL

SNG_STREAM -- requirements
Module: sng_stream

---
 rtl/sng_stream_if.sv | 26 ++
 rtl/sng_stream.sv | 80 ++++++++
 2 files changed

// File: rtl/sng_stream_if.sv
// Handshake/bus bundle between the stochastic number generator and its driver.
interface sng_stream_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 16
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] operand;
  logic [LEN_W-1:0] len;
  logic [31:0]      rnd;
  logic             lfsr_en;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] ones_cnt;

  modport master (
    output start, abort, operand, len, rnd,
    input  lfsr_en, bit_out, bit_valid, busy, done, ones_cnt
  );
  modport slave (
    input  start, abort, operand, len, rnd,
    output lfsr_en, bit_out, bit_valid, busy, done, ones_cnt
  );
endinterface

// File: rtl/sng_stream.sv
// Stochastic number generator: compares the LFSR word against a latched operand
// for len cycles, emitting a unipolar bitstream and counting its ones.
module sng_stream #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  sng_stream_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] op_q;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] ones_q;
  logic             bit_q;
  logic             vld_q;
  logic             hit;
  logic             unused_rnd;

  // Only the low WIDTH bits of the random word take part in the compare.
  assign hit        = bus.rnd[WIDTH-1:0] < op_q;
  assign unused_rnd = ^bus.rnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      rem_q   <= '0;
      ones_q  <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          vld_q <= 1'b0;
          if (bus.start) begin
            ones_q <= '0;
            if (bus.len != '0) begin
              op_q    <= bus.operand;
              rem_q   <= bus.len;
              state_q <= RUN;
            end else begin
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          // Abort wins over both the normal bit and the final-bit completion.
          if (bus.abort) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            bit_q  <= hit;
            vld_q  <= 1'b1;
            ones_q <= ones_q + LEN_W'(hit);
            rem_q  <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= DONE;
          end
        end
        DONE: begin
          vld_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          vld_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.lfsr_en   = (state_q == RUN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.bit_out   = bit_q;
  assign bus.bit_valid = vld_q;
  assign bus.ones_cnt  = ones_q;
endmodule
